// File: rtl/apb_data_ram_if.sv
// APB-style data bus between the CPU data port (master) and the data RAM
// responder (slave). Signal names follow the APB convention.
interface apb_data_ram_if;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_data_ram.sv
// Byte-strobed word RAM responding on the CPU data bus with an APB-style
// setup/access handshake and a fixed number of wait states per transfer.
// Full words only; lane extraction and sign extension live in the CPU.
// Optional feature: define BUS_ERR_EN to flag addresses with any bit set
// above ADDR_WIDTH as out of range (PSLVERR=1, write suppressed, PRDATA=0).
// Without it PSLVERR is tied low and the upper address bits alias.
module apb_data_ram #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input logic           clk,
    input logic           reset,
    apb_data_ram_if.slave bus
);

    localparam int WORD_BITS = ADDR_WIDTH - 2;
    localparam int DEPTH     = 2 ** WORD_BITS;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;

    // transfer attributes captured at the setup phase
    logic [WORD_BITS-1:0] word_q;
    logic                 write_q;
    logic [31:0]          wdata_q;
    logic [3:0]           strb_q;
    logic                 oor_q;

    logic [31:0] mem [DEPTH];

    logic                 setup;
    logic                 latch;
    logic                 commit;
    logic                 ready_next;
    logic                 err_next;
    logic [31:0]          rdata_next;
    logic [WORD_BITS-1:0] bus_word;
    logic                 bus_oor;
    logic [WORD_BITS-1:0] rd_word;
    logic                 rd_oor;
    logic                 rd_write;

    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;

    assign setup    = bus.PSEL & ~bus.PENABLE;
    assign bus_word = bus.PADDR[ADDR_WIDTH-1:2];

`ifdef BUS_ERR_EN
    logic unused_lsb;
    assign unused_lsb = ^bus.PADDR[1:0];
    assign bus_oor    = |bus.PADDR[31:ADDR_WIDTH];
`else
    logic unused_addr;
    assign unused_addr = ^{bus.PADDR[31:ADDR_WIDTH], bus.PADDR[1:0]};
    assign bus_oor     = 1'b0;
`endif

    // next-state, counter and registered-output values
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        commit     = 1'b0;
        ready_next = 1'b0;
        rd_word    = word_q;
        rd_oor     = oor_q;
        rd_write   = write_q;
        case (state)
            S_IDLE: begin
                if (setup) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        // zero-wait: data is fetched from the live bus address
                        // because the latches only fill at this same edge
                        state_next = S_READY;
                        ready_next = 1'b1;
                        rd_word    = bus_word;
                        rd_oor     = bus_oor;
                        rd_write   = bus.PWRITE;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.PSEL) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = S_READY;
                    ready_next = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_READY: begin
                state_next = S_IDLE;
                commit     = bus.PSEL & bus.PENABLE & write_q & ~oor_q;
            end
            default: state_next = S_IDLE;
        endcase
        err_next   = ready_next & rd_oor;
        rdata_next = (ready_next && !rd_write && !rd_oor) ? mem[rd_word] : '0;
    end

    // FSM state, wait counter and bus response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ready_q <= ready_next;
            err_q   <= err_next;
            rdata_q <= rdata_next;
        end
    end

    // capture the transfer attributes at the setup phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            oor_q   <= 1'b0;
        end else if (latch) begin
            word_q  <= bus_word;
            write_q <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
            strb_q  <= bus.PSTRB;
            oor_q   <= bus_oor;
        end
    end

    // byte-lane write at the closing edge of the ready cycle
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.PREADY = ready_q;
    assign bus.PRDATA = rdata_q;
`ifdef BUS_ERR_EN
    assign bus.PSLVERR = err_q;
`else
    logic unused_err;
    assign unused_err  = err_q;
    assign bus.PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_data_ram.sv
// Bench for apb_data_ram: two instances (2 and 0 wait states) sharing one
// stimulus driver; transfers come from a vector table with a scoreboard queue,
// plus hand sequences for reset and protocol-abort corner cases.
module tb_apb_data_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;   // 0: two-wait instance, 1: zero-wait instance
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_data_ram_if bus_a ();
    apb_data_ram_if bus_b ();

    assign bus_a.PSEL    = psel & ~sel;
    assign bus_b.PSEL    = psel & sel;
    assign bus_a.PADDR   = paddr;
    assign bus_b.PADDR   = paddr;
    assign bus_a.PENABLE = penable;
    assign bus_b.PENABLE = penable;
    assign bus_a.PWRITE  = pwrite;
    assign bus_b.PWRITE  = pwrite;
    assign bus_a.PWDATA  = pwdata;
    assign bus_b.PWDATA  = pwdata;
    assign bus_a.PSTRB   = pstrb;
    assign bus_b.PSTRB   = pstrb;

    apb_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_ws2 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    apb_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    logic        rdy;
    logic [31:0] rdata;
    logic        err;
    assign rdy   = sel ? bus_b.PREADY  : bus_a.PREADY;
    assign rdata = sel ? bus_b.PRDATA  : bus_a.PRDATA;
    assign err   = sel ? bus_b.PSLVERR : bus_a.PSLVERR;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic        dut;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [31:0] ed, input logic ee);
        vec_t v;
        v.dut = d; v.wr = w; v.addr = a; v.wdata = wd; v.strb = s;
        v.exp_data = ed; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // One full transfer; optionally scrambles PADDR/PWDATA after setup.
    task automatic xfer(input logic d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic [31:0] ed, input logic ee, input bit scramble);
        exp_t e;
        exp_t got;
        int   waits;
        bit   done;
        waits = 0;
        done  = 0;
        @(posedge clk); #1;
        sel = d; psel = 1'b1; penable = 1'b0; pwrite = w;
        paddr = a; pwdata = wd; pstrb = s;
        e.data = ed; e.err = ee;
        sb.push_back(e);
        @(posedge clk); #1;
        penable = 1'b1;
        if (scramble) begin
            paddr  = a ^ 32'h30;
            pwdata = ~wd;
        end
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (rdy) begin
                got = sb.pop_front();
                check("prdata", rdata, got.data);
                check("pslverr", 32'(err), 32'(got.err));
                check("wait_cycles", 32'(waits), d ? 32'd0 : 32'd2);
                done = 1;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            check("pready_timeout", 32'(rdy), 32'd1);
            if (sb.size() > 0) got = sb.pop_front();
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("pready_drop", 32'(rdy), 32'd0);
        check("prdata_idle", rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // two-wait instance
        add(0, 1, 32'h10,   32'hDEADBEEF, 4'b1111, 32'h0,        1'b0);
        add(0, 0, 32'h10,   32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);
        add(0, 1, 32'h12,   32'h11223344, 4'b0100, 32'h0,        1'b0);
        add(0, 0, 32'h10,   32'h0,        4'b0000, 32'hDE22BEEF, 1'b0);
        add(0, 1, 32'h10,   32'hAAAA5555, 4'b1100, 32'h0,        1'b0);
        add(0, 0, 32'h10,   32'h0,        4'b0000, 32'hAAAABEEF, 1'b0);
        add(0, 1, 32'h20,   32'h12345678, 4'b1111, 32'h0,        1'b0);
        add(0, 0, 32'h20,   32'h0,        4'b0000, 32'h12345678, 1'b0);
        add(0, 1, 32'h0,    32'h0BADF00D, 4'b1111, 32'h0,        1'b0);
`ifdef BUS_ERR_EN
        add(0, 1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1);
        add(0, 0, 32'h0,    32'h0,        4'b0000, 32'h0BADF00D, 1'b0);
        add(0, 0, 32'h1000, 32'h0,        4'b0000, 32'h0,        1'b1);
`else
        add(0, 1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b0);
        add(0, 0, 32'h0,    32'h0,        4'b0000, 32'hFFFFFFFF, 1'b0);
        add(0, 0, 32'h1000, 32'h0,        4'b0000, 32'hFFFFFFFF, 1'b0);
`endif
        // zero-wait instance
        add(1, 1, 32'h10,   32'hCAFEF00D, 4'b1111, 32'h0,        1'b0);
        add(1, 0, 32'h10,   32'h0,        4'b0000, 32'hCAFEF00D, 1'b0);
        add(1, 1, 32'h10,   32'h0,        4'b0000, 32'h0,        1'b0);
        add(1, 0, 32'h10,   32'h0,        4'b0000, 32'hCAFEF00D, 1'b0);
        add(1, 1, 32'h3FC,  32'h13579BDF, 4'b1111, 32'h0,        1'b0);
        add(1, 0, 32'h3FC,  32'h0,        4'b0000, 32'h13579BDF, 1'b0);

        // reset state of both instances
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready_a",  32'(bus_a.PREADY),  32'd0);
        check("rst_prdata_a",  bus_a.PRDATA,       32'd0);
        check("rst_pslverr_a", 32'(bus_a.PSLVERR), 32'd0);
        check("rst_pready_b",  32'(bus_b.PREADY),  32'd0);
        check("rst_prdata_b",  bus_b.PRDATA,       32'd0);
        check("rst_pslverr_b", 32'(bus_b.PSLVERR), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 vecs[i].exp_data, vecs[i].exp_err, 1'b0);
        end

        // setup attributes are latched; later bus changes are ignored
        xfer(0, 0, 32'h10, 32'h0,      4'b0000, 32'hAAAABEEF, 1'b0, 1'b1);
        xfer(1, 1, 32'h20, 32'h5A5A5A5A, 4'b1111, 32'h0,      1'b0, 1'b1);
        xfer(1, 0, 32'h20, 32'h0,      4'b0000, 32'h5A5A5A5A, 1'b0, 1'b0);

        // async reset while a read is presenting data
        @(posedge clk); #1;
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_pready", 32'(rdy), 32'd1);
        check("pre_rst_prdata", rdata, 32'hAAAABEEF);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pready",  32'(rdy), 32'd0);
        check("async_rst_prdata",  rdata,    32'd0);
        check("async_rst_pslverr", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;

        // reset during the wait phase of a write aborts it
        @(posedge clk); #1;
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h20; pwdata = 32'h87654321; pstrb = 4'b1111;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("wait_rst_pready", 32'(rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        xfer(0, 0, 32'h20, 32'h0, 4'b0000, 32'h12345678, 1'b0, 1'b0);

        // PSEL dropped during wait: abort, no completion, no write
        @(posedge clk); #1;
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h20; pwdata = 32'hFFFF0000; pstrb = 4'b1111;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_pready", 32'(rdy), 32'd0);
        end
        xfer(0, 0, 32'h20, 32'h0, 4'b0000, 32'h12345678, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
